encrypt_engine: RTL and testbench

ENCRYPT_ENGINE -- requirements
Module: encrypt_engine

---
 rtl/encrypt_engine.sv | 145 ++++++++++++++
 tb/tb_encrypt_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_engine.sv
// encrypt_engine: iterative rotate/XOR block cipher, one round per clock.
// A request is captured in IDLE, runs ROUNDS rounds in RUN, then parks in
// DONE with the result until the consumer takes it.
module encrypt_engine #(
    parameter int DATA_W   = 64,
    parameter int ROUNDS   = 4,
    parameter int DATA_ROT = 3,
    parameter int KEY_ROT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] key_out,
    output logic              status
);

    localparam int CNT_W = $clog2(ROUNDS + 1);
    // Rotation that turns key_in into the final round key, where decryption starts.
    localparam int DEC_KEY_ROT = ((ROUNDS - 1) * KEY_ROT) % DATA_W;

    if (DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
        $error("encrypt_engine: DATA_W must be in 8..128");
    end
    if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
        $error("encrypt_engine: ROUNDS must be in 1..16");
    end
    if (DATA_ROT < 1 || DATA_ROT > DATA_W - 1) begin : g_bad_data_rot
        $error("encrypt_engine: DATA_ROT must be in 1..DATA_W-1");
    end
    if (KEY_ROT < 1 || KEY_ROT > DATA_W - 1) begin : g_bad_key_rot
        $error("encrypt_engine: KEY_ROT must be in 1..DATA_W-1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] key_q;
    logic              accept;
    logic              last_round;

    // Rotation by 0 is legal: the right shift by DATA_W yields zero.
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
        rotl = (x << n) | (x >> (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        rotr = (x >> n) | (x << (DATA_W - n));
    endfunction

    assign accept     = (state == IDLE) && in_valid;
    assign last_round = (cnt == CNT_W'(ROUNDS - 1));

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs; results are masked outside DONE.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        status     = 1'b0;
        data_out   = '0;
        key_out    = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                status = 1'b1;
                if (last_round) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                status    = 1'b1;
                out_valid = 1'b1;
                data_out  = data_q;
                key_out   = key_q;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Round counter: cleared on accept, one step per RUN cycle, ends at ROUNDS.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Datapath: capture the request, then apply one round per RUN cycle.
    // The key is not advanced after the final round so key_out shows the
    // last round key actually used.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mode_q <= mode;
            data_q <= data_in;
            key_q  <= mode ? rotl(key_in, DEC_KEY_ROT) : key_in;
        end else if (state == RUN) begin
            if (!mode_q) begin
                data_q <= rotl(data_q ^ key_q, DATA_ROT);
                if (!last_round) begin
                    key_q <= rotl(key_q, KEY_ROT);
                end
            end else begin
                data_q <= rotr(data_q, DATA_ROT) ^ key_q;
                if (!last_round) begin
                    key_q <= rotr(key_q, KEY_ROT);
                end
            end
        end
    end

endmodule

// File: tb/tb_encrypt_engine.sv
// Testbench for encrypt_engine: three configurations against a round-key
// reference model, plus handshake, stall, reset and back-to-back scenarios.
`timescale 1ns/1ps
module tb_encrypt_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        drv_valid, drv_ready, drv_mode;
    logic [63:0] drv_data, drv_key;

    int checks   = 0;
    int failures = 0;

    // Instance 0: defaults. Instance 1: 64/1/1/1. Instance 2: 8/16/7/3.
    logic        m_in_ready, m_out_valid, m_status;
    logic [63:0] m_dout, m_kout;
    logic        a_in_ready, a_out_valid, a_status;
    logic [63:0] a_dout, a_kout;
    logic        b_in_ready, b_out_valid, b_status;
    logic [7:0]  b_dout, b_kout;

    encrypt_engine u_main (
        .clk(clk), .rst(rst), .in_valid(drv_valid && (sel == 0)), .in_ready(m_in_ready),
        .mode(drv_mode), .data_in(drv_data), .key_in(drv_key), .out_valid(m_out_valid),
        .out_ready(drv_ready && (sel == 0)), .data_out(m_dout), .key_out(m_kout), .status(m_status)
    );

    encrypt_engine #(.DATA_W(64), .ROUNDS(1), .DATA_ROT(1), .KEY_ROT(1)) u_one (
        .clk(clk), .rst(rst), .in_valid(drv_valid && (sel == 1)), .in_ready(a_in_ready),
        .mode(drv_mode), .data_in(drv_data), .key_in(drv_key), .out_valid(a_out_valid),
        .out_ready(drv_ready && (sel == 1)), .data_out(a_dout), .key_out(a_kout), .status(a_status)
    );

    encrypt_engine #(.DATA_W(8), .ROUNDS(16), .DATA_ROT(7), .KEY_ROT(3)) u_small (
        .clk(clk), .rst(rst), .in_valid(drv_valid && (sel == 2)), .in_ready(b_in_ready),
        .mode(drv_mode), .data_in(drv_data[7:0]), .key_in(drv_key[7:0]), .out_valid(b_out_valid),
        .out_ready(drv_ready && (sel == 2)), .data_out(b_dout), .key_out(b_kout), .status(b_status)
    );

    logic        cur_in_ready, cur_out_valid, cur_status;
    logic [63:0] cur_dout, cur_kout;

    always_comb begin
        cur_in_ready  = m_in_ready;
        cur_out_valid = m_out_valid;
        cur_status    = m_status;
        cur_dout      = m_dout;
        cur_kout      = m_kout;
        if (sel == 1) begin
            cur_in_ready  = a_in_ready;
            cur_out_valid = a_out_valid;
            cur_status    = a_status;
            cur_dout      = a_dout;
            cur_kout      = a_kout;
        end else if (sel == 2) begin
            cur_in_ready  = b_in_ready;
            cur_out_valid = b_out_valid;
            cur_status    = b_status;
            cur_dout      = {56'd0, b_dout};
            cur_kout      = {56'd0, b_kout};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl_w(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        int          s;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x & m;
        s = n % w;
        if (s == 0) return x;
        return ((x << s) | (x >> (w - s))) & m;
    endfunction

    function automatic logic [63:0] rotr_w(input logic [63:0] x, input int n, input int w);
        return rotl_w(x, (w - (n % w)) % w, w);
    endfunction

    // Reference: build the round-key schedule, then apply the rounds in order.
    task automatic model(input int s, input logic md, input logic [63:0] x, input logic [63:0] k,
                         output logic [63:0] d, output logic [63:0] kl);
        int          w, r, dr, kr;
        logic [63:0] rk [16];
        case (s)
            1:       begin w = 64; r = 1;  dr = 1; kr = 1; end
            2:       begin w = 8;  r = 16; dr = 7; kr = 3; end
            default: begin w = 64; r = 4;  dr = 3; kr = 1; end
        endcase
        for (int i = 0; i < r; i++) rk[i] = rotl_w(k, (i * kr) % w, w);
        d = rotl_w(x, 0, w);
        if (!md) begin
            for (int i = 0; i < r; i++) d = rotl_w(d ^ rk[i], dr, w);
            kl = rk[r-1];
        end else begin
            for (int i = r - 1; i >= 0; i--) d = rotr_w(d, dr, w) ^ rk[i];
            kl = rk[0];
        end
    endtask

    // One full request on the selected instance; lat counts cycles after the accept cycle.
    task automatic txn(input logic md, input logic [63:0] x, input logic [63:0] k,
                       output logic [63:0] d, output logic [63:0] kl, output int lat);
        int n;
        @(negedge clk);
        drv_mode = md; drv_data = x; drv_key = k; drv_valid = 1'b1; drv_ready = 1'b0;
        n = 0;
        while (!cur_in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!cur_out_valid && lat < 60);
        d = cur_dout; kl = cur_kout;
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    logic [63:0] x, k, d, kl, ed, ek, d2, kl2;
    int          lat, n, seen;
    logic [63:0] bx [5];
    logic [63:0] bk [5];
    logic [63:0] exp_q [$];
    int          acc_q [$];
    int          nacc, nres, prev_acc;
    logic        acc;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 0; drv_valid = 1'b0; drv_ready = 1'b0; drv_mode = 1'b0;
        drv_data = '0; drv_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", cur_in_ready, 1);
        chk("rst_out_valid", cur_out_valid, 0);
        chk("rst_status", cur_status, 0);
        chk("rst_dout", cur_dout, 0);
        chk("rst_kout", cur_kout, 0);
        rst = 1'b0;

        // Single-round known answer.
        sel = 1;
        txn(1'b0, 64'd0, 64'd1, d, kl, lat);
        chk("kat_data", d, 64'h0000000000000002);
        chk("kat_key", kl, 64'h0000000000000001);
        chk("kat_lat", lat, 2);

        // Default configuration: random encrypt/decrypt round trips.
        sel = 0;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom}; k = {$urandom, $urandom};
            if (i == 0) begin x = '0; k = '0; end
            if (i == 1) begin x = '1; k = '1; end
            if (i == 2) begin x = 64'h8000000000000001; k = 64'h0123456789abcdef; end
            model(0, 1'b0, x, k, ed, ek);
            txn(1'b0, x, k, d, kl, lat);
            chk("enc_data", d, ed);
            chk("enc_key", kl, ek);
            chk("enc_lat", lat, 5);
            model(0, 1'b1, d, k, ed, ek);
            txn(1'b1, d, k, d2, kl2, lat);
            chk("dec_roundtrip", d2, x);
            chk("dec_key", kl2, ek);
            chk("dec_lat", lat, 5);
        end

        // Small configuration against the model.
        sel = 2;
        for (int i = 0; i < 1500; i++) begin
            x = 64'($urandom_range(0, 255)); k = 64'($urandom_range(0, 255));
            if (i == 0) begin x = 0; k = 0; end
            if (i == 1) begin x = 255; k = 255; end
            model(2, 1'b0, x, k, ed, ek);
            txn(1'b0, x, k, d, kl, lat);
            chk("small_data", d, ed);
            chk("small_key", kl, ek);
            chk("small_lat", lat, 17);
            if (i < 50) begin
                txn(1'b1, d, k, d2, kl2, lat);
                chk("small_roundtrip", d2, x);
            end
        end

        // Stall in DONE with a competing request.
        sel = 0;
        x = 64'hdeadbeefcafef00d; k = 64'h0f1e2d3c4b5a6978;
        model(0, 1'b0, x, k, ed, ek);
        @(negedge clk);
        drv_mode = 1'b0; drv_data = x; drv_key = k; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        @(negedge clk);
        chk("run_status", cur_status, 1);
        chk("run_in_ready", cur_in_ready, 0);
        chk("run_dout_zero", cur_dout, 0);
        n = 1;
        while (!cur_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("stall_lat", n, 5);
        drv_valid = 1'b1; drv_data = ~x; drv_key = ~k; drv_mode = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("stall_data", cur_dout, ed);
            chk("stall_key", cur_kout, ek);
            chk("stall_in_ready", cur_in_ready, 0);
            chk("stall_out_valid", cur_out_valid, 1);
            @(negedge clk);
        end
        drv_valid = 1'b0; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
        @(negedge clk);
        chk("release_in_ready", cur_in_ready, 1);
        chk("release_out_valid", cur_out_valid, 0);
        chk("release_dout", cur_dout, 0);
        chk("release_status", cur_status, 0);
        seen = 0;
        repeat (8) begin @(negedge clk); if (cur_out_valid || cur_status) seen = 1; end
        chk("ignored_second_req", seen, 0);

        // Reset on the second RUN cycle.
        @(negedge clk);
        drv_mode = 1'b0; drv_data = x; drv_key = k; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        @(negedge clk);
        chk("midrun_status", cur_status, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_in_ready", cur_in_ready, 1);
        chk("midrun_status_clr", cur_status, 0);
        chk("midrun_out_valid", cur_out_valid, 0);
        chk("midrun_dout", cur_dout, 0);
        chk("midrun_kout", cur_kout, 0);
        seen = 0;
        repeat (10) begin @(negedge clk); if (cur_out_valid) seen = 1; end
        chk("midrun_no_output", seen, 0);

        // Request presented together with reset is not taken.
        @(negedge clk);
        rst = 1'b1; drv_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; drv_valid = 1'b0;
        @(negedge clk);
        chk("rst_valid_status", cur_status, 0);
        chk("rst_valid_in_ready", cur_in_ready, 1);

        // Back-to-back with out_ready tied high.
        for (int i = 0; i < 5; i++) begin bx[i] = {$urandom, $urandom}; bk[i] = {$urandom, $urandom}; end
        nacc = 0; nres = 0; prev_acc = -1;
        @(negedge clk);
        drv_ready = 1'b1; drv_mode = 1'b0; drv_data = bx[0]; drv_key = bk[0]; drv_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk);
            acc = 1'b0;
            if (cur_out_valid) begin
                if (exp_q.size() > 0) begin
                    chk("b2b_data", cur_dout, exp_q.pop_front());
                    chk("b2b_lat", c - acc_q.pop_front(), 5);
                end else begin
                    chk("b2b_unexpected", cur_out_valid, 0);
                end
                nres++;
            end
            if (drv_valid && cur_in_ready) begin
                acc = 1'b1;
                if (prev_acc >= 0) chk("b2b_interval", c - prev_acc, 6);
                prev_acc = c;
                acc_q.push_back(c);
                model(0, 1'b0, drv_data, drv_key, ed, ek);
                exp_q.push_back(ed);
            end
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 5) begin drv_data = bx[nacc]; drv_key = bk[nacc]; end
                else drv_valid = 1'b0;
            end
        end
        drv_ready = 1'b0;
        chk("b2b_accepts", nacc, 5);
        chk("b2b_results", nres, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
